// File: rtl/farm_sensor_cond.sv
// ============================================================================
// farm_sensor_cond
// ----------------------------------------------------------------------------
// Conditions the raw farm-road vehicle detector into the request signal used
// by the highway/farm-road traffic-light controller.
//
//   sens_raw -> 2-flop synchronizer -> debounce (DEB_CYC cycles) -> det
//   det rising edge = one arrival
//   arrivals + fl_green drive a small request FSM (IDLE / PEND / SERVE);
//   c is high whenever the FSM is out of IDLE.
//
// Optional feature (compile-time macro FARM_CAR_COUNT_EN):
//   When defined, a saturating 0..15 waiting-car counter and a departure
//   timer are built. Each LEAVE_CYC cycles of fl_green in SERVE lets one car
//   leave; the request drops when the last car has left.
//   When undefined, car_cnt is tied to 0, there is no timer, and SERVE is
//   left only when fl_green drops (to PEND if a car is still detected,
//   otherwise to IDLE).
//
// Parameters:
//   DEB_CYC    1..15  consecutive synchronized-high cycles to accept a car
//   LEAVE_CYC  1..255 fl_green cycles needed to serve one car
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   rst       in   synchronous active-low reset
//   sens_raw  in   asynchronous raw detector, 1 = car present
//   fl_green  in   farm-road green from the traffic-light controller
//   c         out  farm-road car request (decoded from registered state)
//   car_cnt   out  number of waiting farm-road cars (0 without the counter)
// ============================================================================
module farm_sensor_cond #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned LEAVE_CYC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sens_raw,
    input  logic       fl_green,
    output logic       c,
    output logic [3:0] car_cnt
);

    // ------------------------------------------------------------------------
    // Parameter sanity: both counters are sized for the documented ranges.
    // ------------------------------------------------------------------------
    if (DEB_CYC < 1 || DEB_CYC > 15 || LEAVE_CYC < 1 || LEAVE_CYC > 255) begin : g_bad_param
        $error("farm_sensor_cond: DEB_CYC must be 1..15 and LEAVE_CYC 1..255");
    end

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_SERVE = 2'd2;

    // Last debounce count value; reaching it with input still high is an arrival.
    localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

    // ------------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------------
    logic sync_q1;
    logic sync_q2;

    // NOTE: clocked state is always written with non-blocking (<=) assignments
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sens_raw;
            sync_q2 <= sync_q1;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce
    // deb_cnt counts synchronized-high cycles already seen. On the DEB_CYC-th
    // consecutive high cycle det is set; that same edge is the arrival, so the
    // FSM reacts on the edge det rises rather than one cycle later.
    // ------------------------------------------------------------------------
    logic [3:0] deb_cnt;
    logic       det;
    logic       arrival;

    assign arrival = sync_q2 && !det && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            deb_cnt <= '0;
            det     <= 1'b0;
        end else if (!sync_q2) begin
            // Any low sample restarts the qualification window.
            deb_cnt <= '0;
            det     <= 1'b0;
        end else if (arrival) begin
            det     <= 1'b1;
        end else if (!det) begin
            deb_cnt <= deb_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Request FSM state register
    // ------------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // c is a pure decode of the state register, so it carries no combinational
    // path from the inputs.
    assign c = (state_q != ST_IDLE);

`ifdef FARM_CAR_COUNT_EN

    // ------------------------------------------------------------------------
    // Departure timer: runs only while serving with green; a departure fires
    // on its last count and the timer restarts from zero.
    // ------------------------------------------------------------------------
    localparam logic [7:0] LEAVE_LAST = 8'(LEAVE_CYC - 1);

    logic [7:0] leave_tmr;
    logic       depart;
    logic [3:0] car_cnt_q;
    logic [3:0] car_cnt_d;

    assign depart = (state_q == ST_SERVE) && fl_green && (leave_tmr == LEAVE_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            leave_tmr <= '0;
        end else if (depart) begin
            leave_tmr <= '0;
        end else if ((state_q == ST_SERVE) && fl_green) begin
            leave_tmr <= leave_tmr + 8'd1;
        end else begin
            leave_tmr <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Waiting-car counter
    // An arrival and a departure on the same edge cancel out. The counter
    // saturates at 15 and never goes below 0.
    // ------------------------------------------------------------------------
    // NOTE: combinational blocks assign a default to every output first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        car_cnt_d = car_cnt_q;
        if (arrival && !depart) begin
            if (car_cnt_q != 4'd15) begin
                car_cnt_d = car_cnt_q + 4'd1;
            end
        end else if (depart && !arrival) begin
            if (car_cnt_q != 4'd0) begin
                car_cnt_d = car_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            car_cnt_q <= '0;
        end else begin
            car_cnt_q <= car_cnt_d;
        end
    end

    assign car_cnt = car_cnt_q;

    // ------------------------------------------------------------------------
    // Next-state logic (counter build)
    // Leaving SERVE looks at the updated count, so an arrival on the same edge
    // as the last departure, or as green ending, keeps the request alive.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arrival) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (fl_green) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (fl_green) begin
                    if (depart && (car_cnt_d == 4'd0)) begin
                        state_d = ST_IDLE;
                    end
                end else if (car_cnt_d == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`else

    // ------------------------------------------------------------------------
    // No counter: a single outstanding request. SERVE is held for as long as
    // green lasts; when green ends, a car still sitting on the detector
    // re-requests, otherwise the request drops.
    // ------------------------------------------------------------------------
    assign car_cnt = 4'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arrival) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (fl_green) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!fl_green) begin
                    state_d = det ? ST_PEND : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`endif

endmodule

// File: tb/tb_farm_sensor_cond.sv
// ============================================================================
// tb_farm_sensor_cond
// ----------------------------------------------------------------------------
// Scoreboard bench for farm_sensor_cond. Each stimulus cycle advances a
// behavioural model (run lengths of synchronized high samples, an integer
// car count, a "green cycles served" timer) and queues the expected c and
// car_cnt for that edge. A monitor pops one entry per cycle on the falling
// edge and compares. Directed scenarios add fixed-value checks at known
// points; a random phase follows. Works with and without FARM_CAR_COUNT_EN.
// ============================================================================
module tb_farm_sensor_cond;

    localparam int DEB = 4;
    localparam int LV  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_PEND  = 1;
    localparam int M_SERVE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sens_raw = 1'b0;
    logic       fl_green = 1'b0;
    logic       c;
    logic [3:0] car_cnt;

    always #5 clk = ~clk;

    farm_sensor_cond #(
        .DEB_CYC   (DEB),
        .LEAVE_CYC (LV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sens_raw (sens_raw),
        .fl_green (fl_green),
        .c        (c),
        .car_cnt  (car_cnt)
    );

    typedef struct packed {
        logic       c;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    bit   stim_done = 1'b0;

    // Reference model state
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;
    int m_run  = 0;       // consecutive synchronized-high cycles seen
    int m_mode = M_IDLE;
    int m_cars = 0;
    int m_tmr  = 0;       // green cycles spent on the current car

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of one rising edge with the given inputs.
    task automatic model_step(input bit r, input bit raw, input bit green);
        int run_new;
        bit arrival;
`ifdef FARM_CAR_COUNT_EN
        bit depart;
        int cars_new;
`else
        bit det_old;
`endif
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_run = 0;
            m_mode = M_IDLE; m_cars = 0; m_tmr = 0;
            return;
        end
`ifndef FARM_CAR_COUNT_EN
        det_old = (m_run >= DEB);
`endif
        run_new = m_s2 ? ((m_run < 255) ? m_run + 1 : 255) : 0;
        arrival = (run_new == DEB);
        m_s2  = m_s1;
        m_s1  = raw;
        m_run = run_new;
`ifdef FARM_CAR_COUNT_EN
        depart   = (m_mode == M_SERVE) && green && (m_tmr == LV - 1);
        cars_new = m_cars;
        if (arrival && !depart)      cars_new = (m_cars < 15) ? m_cars + 1 : 15;
        else if (depart && !arrival) cars_new = (m_cars > 0) ? m_cars - 1 : 0;
        if (depart)                              m_tmr = 0;
        else if (m_mode == M_SERVE && green)     m_tmr = m_tmr + 1;
        else                                     m_tmr = 0;
        case (m_mode)
            M_IDLE:  if (arrival) m_mode = M_PEND;
            M_PEND:  if (green)   m_mode = M_SERVE;
            default: begin
                if (green) begin
                    if (depart && cars_new == 0) m_mode = M_IDLE;
                end else begin
                    m_mode = (cars_new == 0) ? M_IDLE : M_PEND;
                end
            end
        endcase
        m_cars = cars_new;
`else
        case (m_mode)
            M_IDLE:  if (arrival) m_mode = M_PEND;
            M_PEND:  if (green)   m_mode = M_SERVE;
            default: if (!green)  m_mode = det_old ? M_PEND : M_IDLE;
        endcase
        m_cars = 0;
`endif
    endtask

    // Drive one cycle, queue its expected outputs, wait for the falling edge.
    task automatic step(input bit r, input bit raw, input bit green);
        exp_t e;
        rst      = r;
        sens_raw = raw;
        fl_green = green;
        model_step(r, raw, green);
        e.c   = (m_mode != M_IDLE);
        e.cnt = 4'(m_cars);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // One clean debounced arrival: 6 cycles high, then 3 low so det clears.
    task automatic arrive(input bit green);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, green);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, green);
    endtask

    // Monitor: one comparison pair per clock, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_c", 32'(c), 32'(e.c));
                check("sb_car_cnt", 32'(car_cnt), 32'(e.cnt));
            end else if (!stim_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got empty queue, expected an entry (t=%0t)", $time);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  raw_hold   = 0;
        int  green_hold = 0;
        bit  raw_v      = 1'b0;
        bit  green_v    = 1'b0;
        bit  rst_v;

        // Reset held two edges with the detector active.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rst_c", 32'(c), 0);
        check("rst_car_cnt", 32'(car_cnt), 0);

        // Release with car present: c must rise on the 6th edge.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        check("c_before_edge6", 32'(c), 0);
        step(1'b1, 1'b1, 1'b0);
        check("c_at_edge6", 32'(c), 1);
`ifdef FARM_CAR_COUNT_EN
        check("cnt_at_edge6", 32'(car_cnt), 1);
`endif

        // Reset in the middle of a pending request.
        step(1'b0, 1'b1, 1'b0);
        check("midrst_c", 32'(c), 0);
        check("midrst_car_cnt", 32'(car_cnt), 0);
        step(1'b0, 1'b0, 1'b0);

        // Glitch of DEB_CYC-1 cycles is ignored.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        check("glitch_c", 32'(c), 0);
        check("glitch_car_cnt", 32'(car_cnt), 0);

        // Service of two cars with green held.
        arrive(1'b0);
        arrive(1'b0);
        check("svc_pend_c", 32'(c), 1);
`ifdef FARM_CAR_COUNT_EN
        check("svc_pend_cnt", 32'(car_cnt), 2);
`endif
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
`ifdef FARM_CAR_COUNT_EN
        check("svc_cnt_before_dep1", 32'(car_cnt), 2);
`endif
        step(1'b1, 1'b0, 1'b1);
`ifdef FARM_CAR_COUNT_EN
        check("svc_cnt_after_dep1", 32'(car_cnt), 1);
`endif
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1);
`ifdef FARM_CAR_COUNT_EN
        check("svc_cnt_after_dep2", 32'(car_cnt), 0);
        check("svc_c_dropped", 32'(c), 0);
`else
        check("svc_c_held_in_green", 32'(c), 1);
`endif
        step(1'b1, 1'b0, 1'b0);
        check("svc_c_after_green", 32'(c), 0);

        // Early end of green with three cars waiting.
        arrive(1'b0);
        arrive(1'b0);
        arrive(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
`ifdef FARM_CAR_COUNT_EN
        check("early_cnt", 32'(car_cnt), 2);
        check("early_c", 32'(c), 1);
`else
        check("early_c", 32'(c), 0);
        check("early_car_cnt", 32'(car_cnt), 0);
`endif
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Saturation: 17 arrivals.
        for (int i = 0; i < 17; i++) arrive(1'b0);
        check("sat_c", 32'(c), 1);
`ifdef FARM_CAR_COUNT_EN
        check("sat_cnt", 32'(car_cnt), 15);
`else
        check("sat_car_cnt", 32'(car_cnt), 0);
`endif

        // Arrival coinciding with the second departure (green edge 17).
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, (k >= 12 && k <= 17), 1'b1);
`ifdef FARM_CAR_COUNT_EN
            if (k == 16) check("simul_cnt_before", 32'(car_cnt), 14);
            if (k == 17) check("simul_cnt_same_edge", 32'(car_cnt), 14);
            if (k == 25) check("simul_cnt_next_dep", 32'(car_cnt), 13);
`endif
        end
        check("simul_c", 32'(c), 1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Arrival, then a one-cycle green pulse with the detector clear.
        arrive(1'b0);
        check("pulse_c_pend", 32'(c), 1);
        step(1'b1, 1'b0, 1'b1);
        check("pulse_c_serve", 32'(c), 1);
        step(1'b1, 1'b0, 1'b0);
`ifdef FARM_CAR_COUNT_EN
        check("pulse_c_after", 32'(c), 1);
        check("pulse_cnt_after", 32'(car_cnt), 1);
`else
        check("pulse_c_after", 32'(c), 0);
        check("pulse_car_cnt", 32'(car_cnt), 0);
`endif

        // Random phase: held input runs around the debounce boundary,
        // random green windows, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if (raw_hold == 0) begin
                raw_v    = 1'($urandom_range(1, 0));
                raw_hold = int'($urandom_range(12, 1));
            end
            if (green_hold == 0) begin
                green_v    = 1'($urandom_range(1, 0));
                green_hold = int'($urandom_range(40, 1));
            end
            rst_v = ($urandom_range(299, 0) != 0);
            step(rst_v, raw_v, green_v);
            raw_hold--;
            green_hold--;
        end

        stim_done = 1'b1;
        #1;
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/farm_sensor_cond.md
FARM_SENSOR_COND -- requirements
Module: farm_sensor_cond

Interface
REQ-001 SHALL have parameter DEB_CYC, default 4, consecutive synchronized-high cycles needed to accept a detection (range 1..15).
REQ-002 SHALL have parameter LEAVE_CYC, default 8, fl_green cycles per served car (range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset at next rising clk edge).
REQ-005 SHALL have port sens_raw  input  1  asynchronous raw farm-road vehicle detector, 1 = car present.
REQ-006 SHALL have port fl_green  input  1  farm-road green from the traffic-light controller.
REQ-007 SHALL have port c  output  1  registered farm-road car request feeding the controller's sensor input.
REQ-008 SHALL have port car_cnt  output  4  registered count of waiting farm-road cars.

Function
REQ-009 SHALL pass sens_raw through a 2-flop synchronizer before any other use.
REQ-010 SHALL drive internal det high once synchronized input has been high DEB_CYC consecutive cycles; any synchronized low clears debounce counter and det the same edge.
REQ-011 SHALL treat each det 0->1 transition as exactly one arrival; pulses shorter than DEB_CYC cycles are ignored.
REQ-012 SHALL, for sens_raw held high, assert c on rising edge DEB_CYC+2 after the first edge sampling sens_raw high (edge 6 at default).
REQ-013 SHALL implement FSM IDLE (c=0), PEND (c=1), SERVE (c=1); c is decoded from registered state only.
REQ-014 SHALL transition IDLE->PEND on arrival; PEND->SERVE on fl_green=1; other inputs hold state.
REQ-015 SHALL, in SERVE with fl_green=1, run departure timer; at count LEAVE_CYC-1 decrement car_cnt (if >0) and restart timer.
REQ-016 SHALL transition SERVE->IDLE when car_cnt reaches 0 via departure, or when fl_green=0 and car_cnt=0.
REQ-017 SHALL transition SERVE->PEND when fl_green=0 and car_cnt>0; timer clears whenever fl_green=0 or state is not SERVE.
REQ-018 SHALL increment car_cnt on arrival, saturating at 15 (further arrivals ignored, no wrap).
REQ-019 SHALL leave car_cnt unchanged when arrival and departure occur on the same edge; an arrival on that edge keeps FSM out of IDLE.
REQ-020 SHALL never decrement car_cnt below 0.

Reset
REQ-021 SHALL, on any rising edge with rst=0, clear synchronizer, debounce counter, det, timer, car_cnt=0, state=IDLE, c=0.
REQ-022 SHALL apply reset mid-operation (any state, any count) with identical result; no arrival is registered on the first edge after release.

Configuration
REQ-023 SHALL compile the car counter only when macro FARM_CAR_COUNT_EN is defined.
REQ-024 SHALL, with FARM_CAR_COUNT_EN defined, behave per REQ-015..REQ-020.
REQ-025 SHALL, without FARM_CAR_COUNT_EN, tie car_cnt to 0, omit timer, and in SERVE on fl_green=0 go IDLE if det=0 else PEND; never leave SERVE while fl_green=1.

Verification
REQ-026 SHALL verify reset: rst=0 for 2 edges with sens_raw=1 -> c=0, car_cnt=0, state IDLE; after release c rises on 6th edge.
REQ-027 SHALL verify glitch rejection: sens_raw high 3 cycles, DEB_CYC=4 -> c stays 0, car_cnt stays 0.
REQ-028 SHALL verify service: 2 debounced arrivals, then fl_green=1 held -> state SERVE, car_cnt 2->1 after 8 cycles, ->0 after 16, c=0 next edge.
REQ-029 SHALL verify early green end: 3 cars, fl_green high 10 cycles then low -> car_cnt=2, state PEND, c=1.
REQ-030 SHALL verify saturation and simultaneity: 17 arrivals -> car_cnt=15; arrival coincident with departure -> car_cnt unchanged.
REQ-031 SHALL verify build without FARM_CAR_COUNT_EN: arrival then fl_green pulse with sens_raw low -> c 1 then 0, car_cnt always 0.
